uart_rx: RTL and testbench

- 8N1 UART receiver paired with the board's baud-rate generation; converts the asynchronous serial line rxd into parallel bytes.
- Uses a 16x-oversampled clock-enable tick derived internally from clk. No derived clocks; a single clock domain throughout.
- Delivers bytes over a valid/ready handshake to the command/game logic. Flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tick_gen.sv | 35 +++
 rtl/uart_rx.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divider math, line levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // An idle line sits high, and a valid stop bit is also high.
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic STOP_LEVEL = 1'b1;

    // Clocks per oversample tick, truncated. The residual error is spread over
    // a whole frame and stays well inside the mid-bit sampling margin.
    function automatic int calc_div(input int clock_rate, input int baud_rate,
                                    input int oversample);
        return clock_rate / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: free-running divider, one-clk tick every DIV clocks.
// Latency: tick is combinational from the counter; first tick DIV clk after reset.
// Backpressure: none; the tick never stalls.
// Ports: clk, rstN (async active-low), tick (1-clk strobe when count == DIV-1).
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rstN,
    output logic tick
);

    localparam int DIV = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampled mid-bit FSM, valid/ready byte output.
// Latency: rxValid rises ~9.5 bit times after the start edge + 2 sync clk + up to DIV clk.
// Backpressure: one-byte holding register; a good byte arriving while it is still full
//               and not being drained is dropped and flagged on overrun.
// Ports: clk, rstN (async active-low), rxd (raw line), rxData/rxValid/rxReady (byte
//        handshake), frameErr (1-clk pulse, bad stop bit), overrun (1-clk pulse, byte dropped).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,    // even, >= 8
    parameter int DATA_BITS  = 8      // >= 2
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    input  logic                 rxReady,
    output logic                 frameErr,
    output logic                 overrun
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Tick source
    // ------------------------------------------------------------------
    logic tick;

    uart_tick_gen #(
        .CLOCK_RATE (CLOCK_RATE),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_gen (
        .clk  (clk),
        .rstN (rstN),
        .tick (tick)
    );

    // ------------------------------------------------------------------
    // Synchronizer: flops reset to the idle level so reset never looks
    // like a start bit.
    // ------------------------------------------------------------------
    logic rxd_meta;
    logic rxs;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rxd_meta <= LINE_IDLE;
            rxs      <= LINE_IDLE;
        end else begin
            rxd_meta <= rxd;
            rxs      <= rxd_meta;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    rx_state_t state;
    rx_state_t state_nxt;

    logic [SW-1:0]        sample_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;

    logic half_pt;
    logic bit_pt;
    logic last_bit;

    assign half_pt  = (sample_cnt == HALF_LAST);
    assign bit_pt   = (sample_cnt == FULL_LAST);
    assign last_bit = (bit_idx == BIT_LAST);

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (tick && (rxs != LINE_IDLE)) state_nxt = START;
            end
            START: begin
                // Start bit must still be low at its middle, else it was a glitch.
                if (tick && half_pt) state_nxt = (rxs == LINE_IDLE) ? IDLE : DATA;
            end
            DATA: begin
                if (tick && bit_pt && last_bit) state_nxt = STOP;
            end
            STOP: begin
                if (tick && bit_pt) state_nxt = (rxs == STOP_LEVEL) ? IDLE : BREAK;
            end
            BREAK: begin
                // A held-low line must return high before a new start is accepted,
                // so a long break reports only one framing error.
                if (rxs == LINE_IDLE) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control strobes
    logic cnt_clr;
    logic cnt_inc;
    logic idx_clr;
    logic shift_en;
    logic stop_good;
    logic stop_bad;
    logic load_byte;
    logic drop_byte;

    always_comb begin
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        idx_clr   = 1'b0;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (tick && (rxs != LINE_IDLE)) cnt_clr = 1'b1;
            end
            START: begin
                if (tick) begin
                    if (half_pt) begin
                        cnt_clr = 1'b1;
                        idx_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_pt) begin
                        shift_en = 1'b1;
                        cnt_clr  = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_pt) begin
                        cnt_clr   = 1'b1;
                        stop_good = (rxs == STOP_LEVEL);
                        stop_bad  = (rxs != STOP_LEVEL);
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // The holding register is free if empty or being drained this same clk.
        load_byte = stop_good && (!rxValid || rxReady);
        drop_byte = stop_good && rxValid && !rxReady;
    end

    // ------------------------------------------------------------------
    // Datapath: counters, shift register, holding register, flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sample_cnt <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
        end else begin
            if (cnt_clr) begin
                sample_cnt <= '0;
            end else if (cnt_inc) begin
                sample_cnt <= sample_cnt + 1'b1;
            end

            if (idx_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end

            // LSB arrives first, so shifting in at the top leaves it at bit 0.
            if (shift_en) begin
                shreg <= {rxs, shreg[DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rxData   <= '0;
            rxValid  <= 1'b0;
            frameErr <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (load_byte) begin
                rxData  <= shreg;
                rxValid <= 1'b1;
            end else if (rxValid && rxReady) begin
                rxValid <= 1'b0;
            end
            frameErr <= stop_bad;
            overrun  <= drop_byte;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns / 1ps
module tb_uart_rx;
    import uart_pkg::*;

    // Scaled-down baud (DIV = 10, 160 clk/bit) keeps the run short; the
    // +/-2% cases use 157 and 163 clk/bit.
    localparam int CLK_HZ = 100000000;
    localparam int BAUD   = 625000;
    localparam int BIT    = 160;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady = 1'b0;
    logic       frameErr;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx #(
        .CLOCK_RATE (CLK_HZ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .rxd      (rxd),
        .rxData   (rxData),
        .rxValid  (rxValid),
        .rxReady  (rxReady),
        .frameErr (frameErr),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Event monitor, sampled on the falling edge away from DUT updates.
    int         rx_count   = 0;
    int         fe_count   = 0;
    int         ov_count   = 0;
    int         vld_cycles = 0;
    logic [7:0] rx_log [0:63];

    always @(negedge clk) begin
        if (rstN) begin
            if (rxValid && rxReady) begin
                rx_log[rx_count[5:0]] <= rxData;
                rx_count <= rx_count + 1;
            end
            if (frameErr) fe_count <= fe_count + 1;
            if (overrun)  ov_count <= ov_count + 1;
            if (rxValid)  vld_cycles <= vld_cycles + 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] last_rx();
        logic [5:0] idx;
        idx = 6'(rx_count - 1);
        return rx_log[idx];
    endfunction

    task automatic drive_bit(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int per, input logic stop_lvl);
        drive_bit(1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(b[i], per);
        drive_bit(stop_lvl, per);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 rxReady = v;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (rxData !== 8'h00) begin n_fail++; $display("FAIL reset_rxData: got %h want 00", rxData); end
        n_checks++; if (rxValid !== 1'b0) begin n_fail++; $display("FAIL reset_rxValid: got %b want 0", rxValid); end
        n_checks++; if (frameErr !== 1'b0) begin n_fail++; $display("FAIL reset_frameErr: got %b want 0", frameErr); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        rstN = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int b0, f0, o0, v0;
        set_ready(1'b1);
        b0 = rx_count; f0 = fe_count; o0 = ov_count; v0 = vld_cycles;
        send_byte(8'hA5, BIT, 1'b1);
        drive_bit(1'b1, 2 * BIT);
        n_checks++; if (rx_count - b0 !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", rx_count - b0); end
        n_checks++; if (last_rx() !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", last_rx()); end
        n_checks++; if (vld_cycles - v0 !== 1) begin n_fail++; $display("FAIL single_valid_len: got %0d want 1", vld_cycles - v0); end
        n_checks++; if (fe_count - f0 !== 0) begin n_fail++; $display("FAIL single_frameErr: got %0d want 0", fe_count - f0); end
        n_checks++; if (ov_count - o0 !== 0) begin n_fail++; $display("FAIL single_overrun: got %0d want 0", ov_count - o0); end
    endtask

    task automatic test_glitch();
        int b0, f0;
        b0 = rx_count; f0 = fe_count;
        drive_bit(1'b0, 37);
        drive_bit(1'b1, 2 * BIT);
        n_checks++; if (rx_count - b0 !== 0) begin n_fail++; $display("FAIL glitch_bytes: got %0d want 0", rx_count - b0); end
        n_checks++; if (fe_count - f0 !== 0) begin n_fail++; $display("FAIL glitch_frameErr: got %0d want 0", fe_count - f0); end
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL glitch_state: got %0d want %0d", dut.state, IDLE); end
        send_byte(8'h3C, BIT, 1'b1);
        drive_bit(1'b1, 2 * BIT);
        n_checks++; if (rx_count - b0 !== 1) begin n_fail++; $display("FAIL glitch_next_count: got %0d want 1", rx_count - b0); end
        n_checks++; if (last_rx() !== 8'h3C) begin n_fail++; $display("FAIL glitch_next_data: got %h want 3c", last_rx()); end
    endtask

    task automatic test_frame_err();
        int b0, f0, v0;
        b0 = rx_count; f0 = fe_count; v0 = vld_cycles;
        send_byte(8'h3C, BIT, 1'b0);
        drive_bit(1'b0, 20 * BIT);
        drive_bit(1'b1, 2 * BIT);
        n_checks++; if (fe_count - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", fe_count - f0); end
        n_checks++; if (vld_cycles - v0 !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d cycles want 0", vld_cycles - v0); end
        n_checks++; if (rx_count - b0 !== 0) begin n_fail++; $display("FAIL ferr_bytes: got %0d want 0", rx_count - b0); end
        send_byte(8'h7E, BIT, 1'b1);
        drive_bit(1'b1, 2 * BIT);
        n_checks++; if (rx_count - b0 !== 1) begin n_fail++; $display("FAIL ferr_next_count: got %0d want 1", rx_count - b0); end
        n_checks++; if (last_rx() !== 8'h7E) begin n_fail++; $display("FAIL ferr_next_data: got %h want 7e", last_rx()); end
    endtask

    task automatic test_back_to_back();
        int b0, o0;
        set_ready(1'b0);
        b0 = rx_count; o0 = ov_count;
        send_byte(8'h11, BIT, 1'b1);
        send_byte(8'h22, BIT, 1'b1);
        drive_bit(1'b1, BIT);
        n_checks++; if (rxData !== 8'h11) begin n_fail++; $display("FAIL b2b_data: got %h want 11", rxData); end
        n_checks++; if (rxValid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", rxValid); end
        n_checks++; if (ov_count - o0 !== 1) begin n_fail++; $display("FAIL b2b_overrun: got %0d want 1", ov_count - o0); end
        n_checks++; if (rx_count - b0 !== 0) begin n_fail++; $display("FAIL b2b_no_accept: got %0d want 0", rx_count - b0); end
        set_ready(1'b1);
        set_ready(1'b0);
        @(negedge clk);
        n_checks++; if (rxValid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_clear: got %b want 0", rxValid); end
        n_checks++; if (rx_count - b0 !== 1) begin n_fail++; $display("FAIL b2b_accept_count: got %0d want 1", rx_count - b0); end
        n_checks++; if (last_rx() !== 8'h11) begin n_fail++; $display("FAIL b2b_accept_data: got %h want 11", last_rx()); end
    endtask

    task automatic test_reset_mid_frame();
        int b0, f0, o0;
        logic [7:0] v;
        v = 8'hC3;
        set_ready(1'b1);
        b0 = rx_count; f0 = fe_count; o0 = ov_count;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_bit(v[i], BIT);
        drive_bit(v[4], BIT / 2);
        rstN = 1'b0;
        #1;
        n_checks++; if (rxData !== 8'h00) begin n_fail++; $display("FAIL midrst_rxData: got %h want 00", rxData); end
        n_checks++; if (rxValid !== 1'b0) begin n_fail++; $display("FAIL midrst_rxValid: got %b want 0", rxValid); end
        n_checks++; if (frameErr !== 1'b0) begin n_fail++; $display("FAIL midrst_frameErr: got %b want 0", frameErr); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d want %0d", dut.state, IDLE); end
        repeat (5) @(negedge clk);
        rxd  = 1'b1;
        rstN = 1'b1;
        drive_bit(1'b1, 2 * BIT);
        n_checks++; if (rx_count - b0 !== 0) begin n_fail++; $display("FAIL midrst_bytes: got %0d want 0", rx_count - b0); end
        n_checks++; if (fe_count - f0 !== 0) begin n_fail++; $display("FAIL midrst_ferr: got %0d want 0", fe_count - f0); end
        send_byte(8'h5A, BIT, 1'b1);
        drive_bit(1'b1, 2 * BIT);
        n_checks++; if (rx_count - b0 !== 1) begin n_fail++; $display("FAIL midrst_next_count: got %0d want 1", rx_count - b0); end
        n_checks++; if (last_rx() !== 8'h5A) begin n_fail++; $display("FAIL midrst_next_data: got %h want 5a", last_rx()); end
        n_checks++; if (ov_count - o0 !== 0) begin n_fail++; $display("FAIL midrst_overrun_cnt: got %0d want 0", ov_count - o0); end
    endtask

    task automatic test_baud_tolerance();
        int         periods [2];
        logic [7:0] bytes   [3];
        int         b0, f0, o0;
        periods = '{157, 163};
        bytes   = '{8'h55, 8'h00, 8'hFF};
        f0 = fe_count; o0 = ov_count;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) begin
                b0 = rx_count;
                send_byte(bytes[k], periods[p], 1'b1);
                drive_bit(1'b1, 2 * BIT);
                n_checks++;
                if ((rx_count - b0 !== 1) || (last_rx() !== bytes[k])) begin
                    n_fail++;
                    $display("FAIL tol_%0d_byte%0d: got %h (count %0d) want %h (count 1)",
                             periods[p], k, last_rx(), rx_count - b0, bytes[k]);
                end
            end
        end
        n_checks++; if (fe_count - f0 !== 0) begin n_fail++; $display("FAIL tol_frameErr: got %0d want 0", fe_count - f0); end
        n_checks++; if (ov_count - o0 !== 0) begin n_fail++; $display("FAIL tol_overrun: got %0d want 0", ov_count - o0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_baud_tolerance();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
